// File: rtl/click_sync_responder_if.sv
// Bundle of signals between an async click sender, the synchronous
// responder and its valid/ready consumer.
// Optional statistics signals exist only when CLICK_SYNC_STATS_EN is defined.
interface click_sync_responder_if #(
  parameter int unsigned DATA_W = 32
);
  logic              inR;
  logic              outA;
  logic [DATA_W-1:0] inData;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              proto_err;
`ifdef CLICK_SYNC_STATS_EN
  logic [15:0]       xfer_cnt;
  logic [7:0]        err_cnt;

  // Responder side
  modport slave (
    input  inR, inData, out_ready,
    output outA, out_data, out_valid, proto_err, xfer_cnt, err_cnt
  );

  // Environment side (sender + consumer)
  modport master (
    output inR, inData, out_ready,
    input  outA, out_data, out_valid, proto_err, xfer_cnt, err_cnt
  );
`else
  // Responder side
  modport slave (
    input  inR, inData, out_ready,
    output outA, out_data, out_valid, proto_err
  );

  // Environment side (sender + consumer)
  modport master (
    output inR, inData, out_ready,
    input  outA, out_data, out_valid, proto_err
  );
`endif
endinterface

// File: rtl/click_sync_responder.sv
// Synchronous responder for a two-phase bundled-data click channel.
// Catches the sender's request, waits a bundling margin, captures the
// data word, hands it to a valid/ready consumer and returns the ack.
// Optional feature macro: CLICK_SYNC_STATS_EN adds xfer_cnt / err_cnt.
module click_sync_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE_CYC  = 1
) (
  input logic                   clk,
  input logic                   rst,
  click_sync_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // The detection edge already consumes one settle cycle, so the counter
  // holds the remaining margin; a zero margin captures straight from IDLE.
  localparam bit         DIRECT   = (SETTLE_CYC == 0);
  localparam logic [3:0] LOAD_VAL = DIRECT ? 4'd0 : 4'(SETTLE_CYC - 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   reqS;
  logic                   reqPrev;
  logic                   ph;
  logic [3:0]             cnt;
  state_t                 state;
  logic [DATA_W-1:0]      dataQ;
  logic                   validQ;
  logic                   protoErr;
  logic                   errEvt;
  logic                   handshake;

  assign reqS = syncQ[SYNC_STAGES-1];

  // Sender toggled twice without an ack: request level fell back to ph.
  assign errEvt    = (state != IDLE) && (reqS == ph) && (reqPrev != ph);
  assign handshake = (state == HOLD) && validQ && bus.out_ready;

  assign bus.outA      = ph;
  assign bus.out_data  = dataQ;
  assign bus.out_valid = validQ;
  assign bus.proto_err = protoErr;

  // Request synchronizer into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], bus.inR};
    end
  end

  // Transfer FSM: detect, settle, capture, hold until consumed, ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ph       <= 1'b0;
      cnt      <= '0;
      dataQ    <= '0;
      validQ   <= 1'b0;
      protoErr <= 1'b0;
      reqPrev  <= 1'b0;
    end else begin
      reqPrev <= reqS;
      if (errEvt) begin
        protoErr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (reqS != ph) begin
            if (DIRECT) begin
              dataQ  <= bus.inData;
              validQ <= 1'b1;
              state  <= HOLD;
            end else begin
              cnt   <= LOAD_VAL;
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            dataQ  <= bus.inData;
            validQ <= 1'b1;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            validQ <= 1'b0;
            ph     <= ~ph;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CLICK_SYNC_STATS_EN
  logic [15:0] xferCnt;
  logic [7:0]  errCnt;

  assign bus.xfer_cnt = xferCnt;
  assign bus.err_cnt  = errCnt;

  // Transfer counter wraps, error counter saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xferCnt <= '0;
      errCnt  <= '0;
    end else begin
      if (handshake) begin
        xferCnt <= xferCnt + 16'd1;
      end
      if (errEvt && (errCnt != '1)) begin
        errCnt <= errCnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_click_sync_responder.sv
// Self-checking bench for click_sync_responder (SYNC_STAGES=2, SETTLE_CYC=1).
// Reference model: a queue of words launched by the sender, popped in order
// by the consumer, plus transfer/ack counting.
module tb_click_sync_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  click_sync_responder_if #(.DATA_W(32)) bus ();

  click_sync_responder #(
    .DATA_W     (32),
    .SYNC_STAGES(2),
    .SETTLE_CYC (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    bus.inR       = 1'b0;
    bus.out_ready = 1'b0;
    bus.inData    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) checkVal({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Sender toggles inR whenever its last request is acknowledged; consumer
  // checks each accepted word against the launched-word queue.
  task automatic runStream(input int n, input bit rndData, input bit rndReady,
                           input bit rndGap, input logic expProto);
    logic [31:0] q[$];
    logic [31:0] d;
    logic        lastA;
    int          sent = 0;
    int          got  = 0;
    int          acks = 0;
    int          gap  = 0;
    int          cyc  = 0;
    lastA = bus.outA;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.outA !== lastA) begin
        acks++;
        lastA = bus.outA;
      end
      if (sent < n && bus.inR === bus.outA) begin
        if (gap == 0) begin
          d          = rndData ? $urandom : 32'(sent + 1);
          bus.inData = d;
          bus.inR    = ~bus.inR;
          q.push_back(d);
          sent++;
          gap = rndGap ? int'($urandom_range(0, 3)) : 0;
        end else begin
          gap--;
        end
      end
      bus.out_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) checkVal("stream_spurious", 32'd1, 32'd0);
        else checkVal("stream_data", bus.out_data, q.pop_front());
        got++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (bus.outA !== lastA) begin
        acks++;
        lastA = bus.outA;
      end
    end
    checkVal("stream_count", 32'(got), 32'(n));
    checkVal("stream_acks", 32'(acks), 32'(n));
    checkVal("stream_proto", 32'(bus.proto_err), 32'(expProto));
  endtask

  initial begin
    int edges;
    int extra;
    bus.inR       = 1'b0;
    bus.inData    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    doReset();
    checkVal("rst_outA", 32'(bus.outA), 32'd0);
    checkVal("rst_valid", 32'(bus.out_valid), 32'd0);
    checkVal("rst_data", bus.out_data, 32'd0);
    checkVal("rst_proto", 32'(bus.proto_err), 32'd0);

    // Basic transfer and latency
    @(negedge clk);
    bus.inData    = 32'hDEADBEEF;
    bus.inR       = 1'b1;
    bus.out_ready = 1'b1;
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.out_valid) break;
    end
    checkVal("basic_latency", 32'(edges), 32'd4);
    checkVal("basic_data", bus.out_data, 32'hDEADBEEF);
    checkVal("basic_outA_before", 32'(bus.outA), 32'd0);
    @(posedge clk);
    #1;
    checkVal("basic_valid_fall", 32'(bus.out_valid), 32'd0);
    checkVal("basic_outA", 32'(bus.outA), 32'd1);

    // Backpressure: word and ack held while consumer stalls
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.inData    = 32'hCAFEF00D;
    bus.inR       = 1'b0;
    waitValid("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal("bp_valid", 32'(bus.out_valid), 32'd1);
      checkVal("bp_data", bus.out_data, 32'hCAFEF00D);
      checkVal("bp_outA", 32'(bus.outA), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkVal("bp_outA_toggle", 32'(bus.outA), 32'd0);
    checkVal("bp_valid_fall", 32'(bus.out_valid), 32'd0);

    // Back-to-back 1..8, then randomized stream
    runStream(8, 1'b0, 1'b0, 1'b0, 1'b0);
    runStream(40, 1'b1, 1'b1, 1'b1, 1'b0);

    // Protocol violation during HOLD
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.inData    = 32'hA5A50001;
    bus.inR       = ~bus.inR;
    waitValid("pv");
    checkVal("pv_proto_before", 32'(bus.proto_err), 32'd0);
    bus.inR = ~bus.inR;
    repeat (4) @(negedge clk);
    bus.inR = ~bus.inR;
    repeat (4) @(negedge clk);
    checkVal("pv_proto", 32'(bus.proto_err), 32'd1);
    checkVal("pv_valid", 32'(bus.out_valid), 32'd1);
    checkVal("pv_data", bus.out_data, 32'hA5A50001);
    bus.out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    bus.out_ready = 1'b0;
    checkVal("pv_single_delivery", 32'(extra), 32'd0);
    checkVal("pv_proto_sticky", 32'(bus.proto_err), 32'd1);
    checkVal("pv_ack_level", 32'(bus.outA), 32'(bus.inR));

    // Reset mid-HOLD with inR left high
    if (bus.inR === 1'b1) runStream(1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.inData = 32'h12345678;
    bus.inR    = 1'b1;
    waitValid("mr");
    checkVal("mr_proto_before", 32'(bus.proto_err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("mr_valid", 32'(bus.out_valid), 32'd0);
    checkVal("mr_outA", 32'(bus.outA), 32'd0);
    checkVal("mr_proto", 32'(bus.proto_err), 32'd0);
    checkVal("mr_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    waitValid("mr_retry");
    checkVal("mr_retry_data", bus.out_data, 32'h12345678);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    bus.out_ready = 1'b0;
    checkVal("mr_retry_once", 32'(extra), 32'd0);
    checkVal("mr_retry_outA", 32'(bus.outA), 32'd1);

`ifdef CLICK_SYNC_STATS_EN
    // Statistics: transfer count and saturating error count
    doReset();
    checkVal("st_xfer_rst", 32'(bus.xfer_cnt), 32'd0);
    checkVal("st_err_rst", 32'(bus.err_cnt), 32'd0);
    runStream(10, 1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("st_xfer", 32'(bus.xfer_cnt), 32'd10);
    checkVal("st_err_zero", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);
    bus.inR = ~bus.inR;
    waitValid("st");
    for (int i = 0; i < 300; i++) begin
      bus.inR = ~bus.inR;
      repeat (4) @(negedge clk);
      bus.inR = ~bus.inR;
      repeat (4) @(negedge clk);
    end
    checkVal("st_err_sat", 32'(bus.err_cnt), 32'hFF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkVal("st_xfer_final", 32'(bus.xfer_cnt), 32'd11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
